tc_rst_seq: RTL
===============

# tc_rst_seq

Parametrised reset sequencer placed after the clock wizard in the clocking block. It filters the PLL `locked` indication, waits a programmable power-up delay, then releases N_CH reset outputs one after another at a fixed spacing. On loss of lock it re-asserts every output, and on a soft-reset request it re-runs the release sequence. This replaces the single fixed-delay reset output with per-domain staged resets.

## Interface
- N_CH, 2: number of reset outputs, ≥1; bit 0 is released first.
- DEL_W, 11: delay counter width, ≥2; power-up delay D = 2^(DEL_W-1) cycles.
- GAP, 16: cycles between successive channel releases, ≥1.
- FILT, 4: consecutive synchronised-locked cycles required before sequencing, ≥1.

- clki  in  1  system clock; all logic on rising edge.
- rsti_n  in  1  asynchronous, active-low reset.
- locked_i  in  1  PLL lock, asynchronous to clki; 2-flop synchronised internally (locked_s).
- soft_rst_i  in  1  synchronous request, sampled each edge.
- rsto  out  N_CH  active-high resets.
- done_o  out  1  high when all rsto bits are released.
- loss_cnt_o  out  8  lock-loss event count (see Configuration).

## Operation
- Reset (rsti_n=0): state HOLD, rsto all 1, done_o=0, sync flops, filter/delay/gap counters, channel index and loss_cnt_o all 0.
- States: HOLD, DELAY, REL, RUN.
- Filter: counter increments each edge with locked_s=1 (saturates at FILT) and clears on any edge with locked_s=0.
- HOLD: rsto all 1. Moves to DELAY on the edge the filter count reaches FILT. The delay counter is cleared on entry.
- DELAY: delay counter increments each edge. When the counter MSB would set, go to REL, clear rsto[0] and the gap counter on the same edge, and set idx=1.
- REL: gap counter increments. After GAP cycles, clear rsto[idx] and increment idx. When the last bit clears, set done_o=1 on the same edge and go to RUN. If N_CH=1, DELAY goes directly to RUN.
- Lock loss: locked_s=0 in any state sends the block to HOLD. On that edge rsto goes all 1, done_o goes 0, and all counters clear.
- Soft reset: soft_rst_i=1 in DELAY, REL or RUN sets rsto all 1 and done_o=0 on that edge. The state goes to DELAY with counters cleared, and filtering is not repeated. soft_rst_i is ignored in HOLD.
- Priority: lock loss > soft reset > normal progression.
- Released bits stay 0 until lock loss, soft reset or rsti_n.

## Timing
- Edge numbering starts at the first clki edge after rsti_n rises, with locked_i steady high. locked_s=1 after edge 2.
- DELAY is entered at edge 2+FILT.
- rsto[0] falls at edge 2+FILT+D.
- rsto[k] falls at edge 2+FILT+D+k·GAP.
- done_o rises with rsto[N_CH-1].
- Lock-loss latency: if locked_i is low at edge n, rsto is all 1 after edge n+2.
- A locked_i low glitch shorter than one clock may be missed. A low lasting at least one full cycle is always caught.
- Soft-reset latency: if soft_rst_i is sampled at edge n, rsto is all 1 after edge n, and rsto[0] falls at edge n+D.
- All outputs are registered, with no combinational paths from inputs to outputs.

## Configuration
- TC_RST_LOSS_CNT_EN defined:
  - loss_cnt_o is an 8-bit counter that saturates at 255.
  - It increments on each transition into HOLD caused by lock loss from DELAY, REL or RUN. The initial HOLD after reset does not count.
  - Cleared only by rsti_n.
- TC_RST_LOSS_CNT_EN undefined: loss_cnt_o is tied to 0 and no counter logic is built.

## Test plan
Bench parameters unless stated: N_CH=3, DEL_W=4 (D=8), GAP=3, FILT=2.
- Power-up: locked_i=1, rsti_n released → rsto[0] falls at edge 12, rsto[1] at 15, rsto[2] at 18, done_o=1 at 18.
- Lock loss: locked_i=0 at edge 40 while in RUN → rsto=3'b111 and done_o=0 after edge 42. With TC_RST_LOSS_CNT_EN, loss_cnt_o=1. Lock restored at edge 50 → rsto[0] falls at edge 62.
- Filter: locked_i toggles high 1 cycle / low 1 cycle for 20 cycles → rsto stays 3'b111 and the state stays HOLD.
- Soft reset mid-sequence: soft_rst_i pulse at edge 16 (after rsto[1] released) → rsto=3'b111 after edge 16, rsto[0] falls at 24, rsto[2] at 30.
- Priority: soft_rst_i and lock loss reach the FSM on the same edge → state HOLD, and rsto does not release until the filter passes again.
- Saturation (TC_RST_LOSS_CNT_EN defined): 300 lock-loss events → loss_cnt_o=255. With the macro undefined, loss_cnt_o=0 throughout.

Source files
------------

// File: rtl/tc_rst_seq.sv
// tc_rst_seq: filters PLL lock, waits 2^(DEL_W-1) cycles, then releases N_CH resets GAP cycles apart.
// Optional lock-loss event counter on loss_cnt_o when TC_RST_LOSS_CNT_EN is defined.
module tc_rst_seq #(
    parameter int N_CH  = 2,
    parameter int DEL_W = 11,
    parameter int GAP   = 16,
    parameter int FILT  = 4
) (
    input  logic            clki,
    input  logic            rsti_n,
    input  logic            locked_i,
    input  logic            soft_rst_i,
    output logic [N_CH-1:0] rsto,
    output logic            done_o,
    output logic [7:0]      loss_cnt_o
);
    localparam int FW = $clog2(FILT + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam int IW = $clog2(N_CH + 1);
    localparam logic [DEL_W-1:0] DLAST = {1'b0, {(DEL_W-1){1'b1}}};

    typedef enum logic [1:0] {HOLD, DELAY, REL, RUN} state_t;

    state_t            state, state_n;
    logic              lk_m, locked_s;
    logic [FW-1:0]     filt, filt_n;
    logic [DEL_W-1:0]  dcnt, dcnt_n;
    logic [GW-1:0]     gcnt, gcnt_n;
    logic [IW-1:0]     idx, idx_n;
    logic [N_CH-1:0]   rsto_n;
    logic              done_n;

    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            lk_m     <= 1'b0;
            locked_s <= 1'b0;
            state    <= HOLD;
            filt     <= '0;
            dcnt     <= '0;
            gcnt     <= '0;
            idx      <= '0;
            rsto     <= '1;
            done_o   <= 1'b0;
        end else begin
            lk_m     <= locked_i;
            locked_s <= lk_m;
            state    <= state_n;
            filt     <= filt_n;
            dcnt     <= dcnt_n;
            gcnt     <= gcnt_n;
            idx      <= idx_n;
            rsto     <= rsto_n;
            done_o   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        filt_n  = !locked_s ? '0 : (filt == FW'(FILT)) ? filt : filt + FW'(1);
        dcnt_n  = dcnt;
        gcnt_n  = gcnt;
        idx_n   = idx;
        rsto_n  = rsto;
        done_n  = done_o;
        if (!locked_s || (soft_rst_i && state != HOLD)) begin
            // lock loss outranks soft reset; soft reset skips re-filtering
            state_n = locked_s ? DELAY : HOLD;
            dcnt_n  = '0;
            gcnt_n  = '0;
            idx_n   = '0;
            rsto_n  = '1;
            done_n  = 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    rsto_n = '1;
                    if (filt_n == FW'(FILT)) begin
                        state_n = DELAY;
                        dcnt_n  = '0;
                    end
                end
                DELAY: begin
                    dcnt_n = dcnt + DEL_W'(1);
                    if (dcnt == DLAST) begin
                        rsto_n[0] = 1'b0;
                        gcnt_n    = '0;
                        idx_n     = IW'(1);
                        state_n   = (N_CH == 1) ? RUN : REL;
                        done_n    = (N_CH == 1);
                    end
                end
                REL: begin
                    gcnt_n = gcnt + GW'(1);
                    if (gcnt == GW'(GAP - 1)) begin
                        gcnt_n = '0;
                        rsto_n = rsto & ~(N_CH'(1) << idx);
                        idx_n  = idx + IW'(1);
                        if (idx == IW'(N_CH - 1)) begin
                            state_n = RUN;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TC_RST_LOSS_CNT_EN
    logic [7:0] loss;

    // counts only lock losses that abort a sequence or a running system
    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n)
            loss <= 8'd0;
        else if (!locked_s && state != HOLD && loss != 8'hff)
            loss <= loss + 8'd1;
    end

    assign loss_cnt_o = loss;
`else
    assign loss_cnt_o = 8'd0;
`endif
endmodule
